counter_step_ctrl: RTL and testbench

Command sequencer placed directly upstream of `counter_8bit`. It accepts a target count over a valid/ready handshake and drives the counter's enable (`E`) and direction (`M`) so that `Q` moves step by step to the target without wrapping. It watches the counter's `Q` to check that each step happened, then reports completion or a tracking error. It is the only agent driving `E` and `M` in the counter subsystem.

---
 rtl/counter_step_ctrl.sv | 125 ++++++++++++
 tb/tb_counter_step_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_step_ctrl.sv
// Step sequencer for counter_8bit: walks Q to a commanded target one count per cycle.
// Optional abort input is built in when CNT_CTRL_ABORT_EN is defined.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a command; E low, M holds its last value
// RUN   | E high, stepping Q toward tgt and checking Q against exp_cnt
// FIN   | move complete; done pulses for this one cycle
module counter_step_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_target,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             E,
    output logic             M,
    output logic             busy,
    output logic             done,
    output logic             err
`ifdef CNT_CTRL_ABORT_EN
    ,
    input  logic             abort
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             e_nxt, m_nxt, err_nxt;
    logic [WIDTH-1:0] tgt, tgt_nxt;
    logic [WIDTH-1:0] exp_cnt, exp_nxt, exp_step;
    logic             abort_req;

`ifdef CNT_CTRL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Count the counter should show after the step currently being applied.
    assign exp_step = M ? exp_cnt + WIDTH'(1) : exp_cnt - WIDTH'(1);

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == FIN) && !abort_req;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            E       <= 1'b0;
            M       <= 1'b1;
            err     <= 1'b0;
            tgt     <= '0;
            exp_cnt <= '0;
        end else begin
            state   <= state_nxt;
            E       <= e_nxt;
            M       <= m_nxt;
            err     <= err_nxt;
            tgt     <= tgt_nxt;
            exp_cnt <= exp_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        e_nxt     = E;
        m_nxt     = M;
        err_nxt   = err;
        tgt_nxt   = tgt;
        exp_nxt   = exp_cnt;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    tgt_nxt = cmd_target;
                    exp_nxt = cnt_q;
                    err_nxt = 1'b0;
                    if (cmd_target > cnt_q) begin
                        m_nxt     = 1'b1;
                        e_nxt     = 1'b1;
                        state_nxt = RUN;
                    end else if (cmd_target < cnt_q) begin
                        m_nxt     = 1'b0;
                        e_nxt     = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        state_nxt = FIN;
                    end
                end
            end
            RUN: begin
                if (abort_req) begin
                    e_nxt     = 1'b0;
                    state_nxt = IDLE;
                end else if (cnt_q != exp_cnt) begin
                    // Counter did not follow; stop driving it and flag the loss of tracking.
                    e_nxt     = 1'b0;
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (E) begin
                    exp_nxt = exp_step;
                    if (exp_step == tgt) begin
                        e_nxt     = 1'b0;
                        state_nxt = FIN;
                    end
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                e_nxt     = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_counter_step_ctrl.sv
// Scoreboard bench for counter_step_ctrl with a behavioural counter_8bit in the loop.
module tb_counter_step_ctrl;

    logic       Clk;
    logic       Reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_target;
    logic [7:0] cnt_q;
    logic       E;
    logic       M;
    logic       busy;
    logic       done;
    logic       err;
`ifdef CNT_CTRL_ABORT_EN
    logic       abort;
`endif

    logic [7:0] q;
    logic       preset_req;
    logic [7:0] preset_val;
    logic       force_en;
    logic [7:0] force_val;
    int         cyc;
    int         n_assert;
    int         n_fail;

    typedef struct {
        logic [7:0] tgt;
        int         steps;
        bit         up;
        int         kind;      // 0: completes with done, 1: ends in tracking error
        int         acc_cyc;
    } txn_t;

    txn_t sb[$];

    counter_step_ctrl #(.WIDTH(8)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_target(cmd_target),
        .cnt_q(cnt_q),
        .E(E),
        .M(M),
        .busy(busy),
        .done(done),
        .err(err)
`ifdef CNT_CTRL_ABORT_EN
        ,
        .abort(abort)
`endif
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Counter model: steps on enabled edges, presettable by the bench while idle.
    always @(posedge Clk) begin
        if (preset_req) q <= preset_val;
        else if (E)     q <= M ? q + 8'd1 : q - 8'd1;
    end
    assign cnt_q = force_en ? force_val : q;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        n_assert++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                     name, act, act, expv, expv, $time);
        end
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        @(negedge Clk);
        while (!cmd_ready && w < 2000) begin
            @(negedge Clk);
            w++;
        end
        if (w >= 2000) chk("idle_timeout", w, 0);
    endtask

    task automatic preset(input logic [7:0] v);
        wait_idle();
        preset_val = v;
        preset_req = 1'b1;
        @(posedge Clk);
        #1 preset_req = 1'b0;
    endtask

    task automatic issue(input logic [7:0] t, input int kind);
        txn_t       n;
        logic [7:0] q0;
        wait_idle();
        q0         = cnt_q;
        cmd_valid  = 1'b1;
        cmd_target = t;
        @(posedge Clk);
        #1;
        if (kind != 2) begin
            n.tgt     = t;
            n.steps   = (t > q0) ? int'(t) - int'(q0) : int'(q0) - int'(t);
            n.up      = (t > q0);
            n.kind    = kind;
            n.acc_cyc = cyc;
            sb.push_back(n);
        end
        @(negedge Clk);
        cmd_valid = 1'b0;
    endtask

    // Monitor: counts enable cycles and retires scoreboard entries on done / error.
    initial begin
        txn_t t;
        int   e_cnt;
        bit   chk_busy_low;
        bit   err_prev;
        e_cnt        = 0;
        chk_busy_low = 0;
        err_prev     = 0;
        forever begin
            @(negedge Clk);
            if (!Reset) begin
                e_cnt        = 0;
                chk_busy_low = 0;
                err_prev     = 0;
            end else begin
                if (chk_busy_low) begin
                    chk("busy_after_done", busy, 0);
                    chk_busy_low = 0;
                end
                if (E) begin
                    e_cnt++;
                    if (sb.size() > 0) chk("direction", M, sb[0].up);
                end
                if (done) begin
                    if (sb.size() == 0) chk("done_without_cmd", sb.size(), 1);
                    else begin
                        t = sb.pop_front();
                        chk("done_kind", 0, t.kind);
                        chk("final_q", cnt_q, t.tgt);
                        chk("enable_cycles", e_cnt, t.steps);
                        chk("done_latency", cyc - t.acc_cyc, t.steps);
                        chk("err_at_done", err, 0);
                        chk_busy_low = 1;
                    end
                end
                if (err && !err_prev) begin
                    if (sb.size() == 0) chk("err_without_cmd", sb.size(), 1);
                    else begin
                        t = sb.pop_front();
                        chk("err_kind", 1, t.kind);
                        chk("E_after_err", E, 0);
                        chk("busy_after_err", busy, 0);
                    end
                end
                err_prev = err;
                if (!busy) e_cnt = 0;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t;
        logic [7:0] q0;
        txn_t       n;
        n_assert   = 0;
        n_fail     = 0;
        cyc        = 0;
        q          = 8'h00;
        Reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_target = 8'h00;
        preset_req = 1'b0;
        preset_val = 8'h00;
        force_en   = 1'b0;
        force_val  = 8'h00;
`ifdef CNT_CTRL_ABORT_EN
        abort      = 1'b0;
`endif
        #3 Reset = 1'b0;
        #1;
        chk("rst_E", E, 0);
        chk("rst_M", M, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        #1 chk("rst_cmd_ready", cmd_ready, 1);

        // Directed moves: up, down, equal, long up to FF.
        preset(8'h00);
        issue(8'h0A, 0);
        issue(8'h05, 0);
        preset(8'h80);
        issue(8'h80, 0);
        issue(8'hFF, 0);

        // Forced tracking mismatch, then a clean command clears err.
        preset(8'h10);
        issue(8'h40, 1);
        repeat (4) @(negedge Clk);
        force_val = 8'h33;
        force_en  = 1'b1;
        @(negedge Clk);
        force_en = 1'b0;
        chk("err_sticky", err, 1);
        issue(8'h45, 0);

        // Randomized moves.
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 3) == 0) preset(8'($urandom_range(0, 255)));
            wait_idle();
            t = ($urandom_range(0, 5) == 0) ? cnt_q : 8'($urandom_range(0, 255));
            issue(t, 0);
        end

        // Reset in the middle of a run; valid held high across it.
        preset(8'h00);
        issue(8'hF0, 2);
        repeat (5) @(negedge Clk);
        #2;
        Reset      = 1'b0;
        cmd_valid  = 1'b1;
        cmd_target = 8'h20;
        #1;
        chk("midrun_rst_E", E, 0);
        chk("midrun_rst_busy", busy, 0);
        chk("midrun_rst_done", done, 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        #1 chk("post_rst_ready", cmd_ready, 1);
        q0 = cnt_q;
        @(posedge Clk);
        #1;
        n.tgt     = 8'h20;
        n.steps   = int'(8'h20) - int'(q0);
        n.up      = 1'b1;
        n.kind    = 0;
        n.acc_cyc = cyc;
        sb.push_back(n);
        cmd_target = 8'h99;
        repeat (8) @(negedge Clk);
        cmd_valid = 1'b0;

`ifdef CNT_CTRL_ABORT_EN
        // Abort on the third RUN cycle stops Q three steps from the start.
        preset(8'h50);
        issue(8'h60, 2);
        @(negedge Clk);
        @(negedge Clk);
        abort = 1'b1;
        @(negedge Clk);
        abort = 1'b0;
        chk("abort_E", E, 0);
        chk("abort_busy", busy, 0);
        chk("abort_q", cnt_q, 8'h53);
        chk("abort_err", err, 0);
        issue(8'h00, 2);
        @(negedge Clk);
        abort = 1'b1;
        @(negedge Clk);
        abort = 1'b0;
        chk("abort2_busy", busy, 0);
`endif

        wait_idle();
        repeat (3) @(negedge Clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
